// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select with architectural delay slot.
// Optional fetch address exception checking is enabled by defining FETCH_ADDR_EXC_EN.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] IR_D,
  input  logic [31:0] PC4_D,
  input  logic [31:0] rs_D,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] IR_F,
  output logic [31:0] PC4_F,
  output logic        exc_F,
  output logic [4:0]  exc_code_F
);

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Initialiser gives a defined PC from the very start of simulation.
  logic [31:0] pc_q = PC_RESET;
  logic [31:0] pc_d;
  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc;

  assign pc4       = pc_q + 32'd4;
  assign br_target = PC4_D + {{14{IR_D[15]}}, IR_D[15:0], 2'b00};
  assign j_target  = {PC4_D[31:28], IR_D[25:0], 2'b00};

  always_comb begin
    npc = pc4;
    case (npc_sel)
      NPC_SEQ: npc = pc4;
      NPC_BR:  npc = br_taken ? br_target : pc4;
      NPC_J:   npc = j_target;
      NPC_JR:  npc = rs_D;
      default: npc = pc4;
    endcase
  end

  // Reset outranks stall, stall outranks any redirect.
  always_comb begin
    pc_d = pc_q;
    if (reset)
      pc_d = PC_RESET;
    else if (en)
      pc_d = npc;
  end

  always_ff @(posedge CLK) begin
    pc_q <= pc_d;
  end

  assign PC_F    = pc_q;
  assign im_addr = pc_q;
  assign PC4_F   = pc4;

`ifdef FETCH_ADDR_EXC_EN
  logic unused_ir;
  assign unused_ir = ^IR_D[31:26];

  always_comb begin
    exc_F      = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
    exc_code_F = exc_F ? EXC_ADEL : 5'd0;
    IR_F       = exc_F ? 32'h0 : im_rdata;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{IM_LO, IM_HI, IR_D[31:26], EXC_ADEL};

  assign exc_F      = 1'b0;
  assign exc_code_F = 5'd0;
  assign IR_F       = im_rdata;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 fetch_stage SHALL have parameter PC_RESET, default 32'h0000_3000, giving the PC value loaded on reset.
REQ-002 fetch_stage SHALL have parameter IM_LO, default 32'h0000_3000, giving the lowest legal fetch address.
REQ-003 fetch_stage SHALL have parameter IM_HI, default 32'h0000_6FFC, giving the highest legal fetch address.
REQ-004 CLK  input  1  clock; all state updates on the posedge.
REQ-005 reset  input  1  reset; synchronous, active-high, sampled on the posedge of CLK.
REQ-006 en  input  1  PC update enable; low means stall and hold the PC.
REQ-007 npc_sel  input  2  next-PC source from decode: 00 sequential, 01 branch, 10 j/jal, 11 jr.
REQ-008 br_taken  input  1  branch condition result from decode; used only when npc_sel=01.
REQ-009 IR_D  input  32  instruction currently in decode; supplies imm16 and instr_index.
REQ-010 PC4_D  input  32  PC+4 of the instruction in decode.
REQ-011 rs_D  input  32  forwarded rs value for jr.
REQ-012 im_addr  output  32  instruction memory address, equal to PC_F.
REQ-013 im_rdata  input  32  instruction memory read data, combinational from im_addr.
REQ-014 PC_F  output  32  current fetch PC, a registered value.
REQ-015 IR_F  output  32  fetched instruction presented to the IF/ID register.
REQ-016 PC4_F  output  32  PC_F + 4, presented to the IF/ID register.
REQ-017 exc_F  output  1  fetch address exception flag (see Configuration).
REQ-018 exc_code_F  output  5  exception code; 5'd4 (AdEL) when exc_F=1, else 5'd0.

Function
REQ-019 PC_F SHALL be the only architectural state and SHALL update only on a CLK posedge.
REQ-020 PC4_F SHALL be PC_F + 32'd4, computed combinationally with 32-bit wrap-around.
REQ-021 Next PC SHALL be selected as follows:
- 00 -> PC4_F.
- 01 with br_taken=1 -> PC4_D + {{14{IR_D[15]}}, IR_D[15:0], 2'b00}.
- 01 with br_taken=0 -> PC4_F.
- 10 -> {PC4_D[31:28], IR_D[25:0], 2'b00}.
- 11 -> rs_D.
REQ-022 The delay slot SHALL be architectural: a redirect selected while a branch or jump is in decode SHALL take effect on the fetch after the delay-slot instruction, with no flush generated by this block.
REQ-023 When en=1, PC_F SHALL load the selected next PC on the posedge.
REQ-024 When en=0, PC_F SHALL hold its value and redirect inputs SHALL be ignored that cycle; a stall takes priority over a simultaneous redirect.
REQ-025 IR_F SHALL equal im_rdata combinationally when exc_F=0, with zero added latency.
REQ-026 Branch offset arithmetic SHALL be 32-bit modular, with no overflow detection.
REQ-027 A jr target SHALL be loaded unmodified even if it is misaligned; detection happens on the following fetch.

Reset
REQ-028 When reset=1 at a posedge, PC_F SHALL become PC_RESET regardless of en and npc_sel.
REQ-029 After reset, PC4_F SHALL be PC_RESET+4 and exc_F/exc_code_F SHALL be 0 for the default PC_RESET.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending redirect.
REQ-031 The PC register SHALL also be initialised to PC_RESET for simulation start.

Configuration
REQ-032 The macro FETCH_ADDR_EXC_EN SHALL control address-exception checking.
- Defined: exc_F=1 when PC_F[1:0]!=0 or PC_F<IM_LO or PC_F>IM_HI; IR_F SHALL then be 32'h0 (nop) and exc_code_F=5'd4.
- Undefined: exc_F and exc_code_F SHALL be tied to 0, IR_F=im_rdata always, and no comparators SHALL be synthesised.

Verification
REQ-033 Reset, then 3 cycles with en=1, npc_sel=00 -> PC_F shall be 3000, 3004, 3008, 300C; PC4_F = PC_F+4.
REQ-034 PC_F=3010, en=0 for 2 cycles with npc_sel=10 -> PC_F shall hold 3010; after en=1 it redirects to the jump target.
REQ-035 npc_sel=01, br_taken=1, PC4_D=3008, imm=16'hFFFE -> next PC shall be 3000; with br_taken=0 -> next PC shall be PC4_F.
REQ-036 npc_sel=11, rs_D=32'h0000_3002, FETCH_ADDR_EXC_EN defined -> after the posedge exc_F=1, exc_code_F=4, IR_F=0; with the macro undefined -> exc_F=0 and IR_F=im_rdata.
REQ-037 reset asserted together with en=1 and npc_sel=10 -> PC_F shall be 3000 on the next cycle.
